// File: rtl/random_victim_select.sv
// Victim-way selector for the random replacement policy.
// Prefers an invalid, unlocked way. Otherwise it draws LFSR values and
// rejects candidates that are out of range or locked. After MAX_RETRY
// rejected draws it falls back to the lowest-index unlocked way.
// The result is returned to the cache controller with a one-cycle ack.
module random_victim_select #(
  parameter int WAYS      = 4,
  parameter int WAY_BITS  = 2,
  parameter int MAX_RETRY = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic [WAYS-1:0]     valid_mask,
  input  logic [WAYS-1:0]     lock_mask,
  input  logic [4:0]          rnd_data,
  output logic                lfsr_en,
  output logic                ack,
  output logic [WAY_BITS-1:0] victim,
  output logic                victim_was_invalid,
  output logic                no_victim
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DRAW,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [WAYS-1:0]     valid_q, valid_d;
  logic [WAYS-1:0]     lock_q, lock_d;
  logic [3:0]          retry_q, retry_d;
  logic [WAY_BITS-1:0] victim_q, victim_d;
  logic                inv_q, inv_d;
  logic                nov_q, nov_d;
  logic                lfsr_en_q;
  logic                ack_q;

  logic                free_found;
  logic [WAY_BITS-1:0] free_idx;
  logic [WAY_BITS-1:0] unl_idx;
  logic                all_locked;
  logic [WAY_BITS-1:0] cand;
  logic [31:0]         lock_pad;
  logic                cand_ok;
  logic [3:0]          retry_inc;
  logic                unused_rnd;

  // Only the low WAY_BITS of the LFSR word select a way.
  assign unused_rnd = ^rnd_data;

  // Lowest invalid-and-unlocked way and lowest unlocked way of the latched set.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    unl_idx    = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_q[i] && !lock_q[i]) begin
        free_found = 1'b1;
        free_idx   = WAY_BITS'(i);
      end
      if (!lock_q[i]) begin
        unl_idx = WAY_BITS'(i);
      end
    end
  end

  assign all_locked = &lock_q;
  assign cand       = rnd_data[WAY_BITS-1:0];
  // Zero-padded lock vector so an out-of-range candidate indexes safely.
  assign lock_pad   = 32'(lock_q);
  assign cand_ok    = (32'(cand) < 32'(WAYS)) && !lock_pad[cand];
  assign retry_inc  = retry_q + 4'd1;

  // Next-state and result selection.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    lock_d   = lock_q;
    retry_d  = retry_q;
    victim_d = victim_q;
    inv_d    = inv_q;
    nov_d    = nov_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          valid_d = valid_mask;
          lock_d  = lock_mask;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (free_found) begin
          victim_d = free_idx;
          inv_d    = 1'b1;
          nov_d    = 1'b0;
          state_d  = S_DONE;
        end else if (all_locked) begin
          victim_d = '0;
          inv_d    = 1'b0;
          nov_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          retry_d = '0;
          state_d = S_DRAW;
        end
      end
      S_DRAW:  state_d = S_WAIT;
      S_WAIT:  state_d = S_CHECK;
      S_CHECK: begin
        if (cand_ok) begin
          victim_d = cand;
          inv_d    = 1'b0;
          nov_d    = 1'b0;
          state_d  = S_DONE;
        end else begin
          retry_d = retry_inc;
          if (retry_inc < 4'(MAX_RETRY)) begin
            state_d = S_DRAW;
          end else begin
            victim_d = unl_idx;
            inv_d    = 1'b0;
            nov_d    = 1'b0;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and registered outputs; pulses are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      retry_q   <= '0;
      lfsr_en_q <= 1'b0;
      ack_q     <= 1'b0;
      victim_q  <= '0;
      inv_q     <= 1'b0;
      nov_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      lfsr_en_q <= (state_d == S_DRAW);
      ack_q     <= (state_d == S_DONE);
      victim_q  <= victim_d;
      inv_q     <= inv_d;
      nov_q     <= nov_d;
    end
  end

  // Latched set masks; only meaningful after a request, so no reset needed.
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    lock_q  <= lock_d;
  end

  assign lfsr_en            = lfsr_en_q;
  assign ack                = ack_q;
  assign victim             = victim_q;
  assign victim_was_invalid = inv_q;
  assign no_victim          = nov_q;

endmodule
